fully_connected_16_10: RTL and testbench

//   Dense (fully-connected) stage fed by the 8x8->4x4 max-pooling stage.

---
 rtl/fully_connected_16_10.sv | 154 +++++++++++++++
 tb/tb_fully_connected_16_10.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fully_connected_16_10.sv
// ============================================================================
// Module   : fully_connected_16_10
// Brief    : Dense layer that turns 16 pooled 4-bit activations into 10 signed
//            class scores. It processes one input index per cycle, and all
//            output neurons are updated in parallel. The weights are held in
//            an internal register file.
//            Optional macro ARGMAX_EN adds the registered class_out port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fully_connected_16_10 #(
    parameter int N_IN  = 16,
    parameter int IN_W  = 4,
    parameter int N_OUT = 10,
    parameter int W_W   = 8,
    parameter int ACC_W = IN_W + 1 + W_W + $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_flag,
    input  logic [N_IN*IN_W-1:0]   in,
    input  logic                   w_we,
    input  logic [3:0]             w_addr,
    input  logic [N_OUT*W_W-1:0]   w_data,
    output logic                   busy,
    output logic [N_OUT*ACC_W-1:0] out,
`ifdef ARGMAX_EN
    output logic [3:0]             class_out,
`endif
    output logic                   end_flag
);

    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state, w_next;

    logic        [IN_W-1:0]  r_act   [N_IN];
    logic signed [W_W-1:0]   r_w     [N_IN][N_OUT];
    logic signed [ACC_W-1:0] r_acc   [N_OUT];
    logic signed [ACC_W-1:0] r_score [N_OUT];
    logic signed [ACC_W-1:0] w_prod  [N_OUT];
    logic        [IDX_W-1:0] r_idx;
    logic                    r_end;
    logic                    w_accept;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_x;

    assign busy     = (r_state == ST_ACC);
    assign end_flag = r_end;
    assign w_accept = start_flag && !busy;
    assign w_last   = (r_idx == IDX_W'(N_IN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_flag) w_next = ST_ACC;
            ST_ACC:  if (w_last)     w_next = ST_DONE;
            ST_DONE: w_next = start_flag ? ST_ACC : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // The activation is zero-extended, so the signed multiply treats it as
    // unsigned. The low ACC_W bits of the product are then exact.
    always_comb begin
        w_x = {{(ACC_W-IN_W){1'b0}}, r_act[r_idx]};
        for (int j = 0; j < N_OUT; j++) begin
            w_prod[j] = w_x * {{(ACC_W-W_W){r_w[r_idx][j][W_W-1]}}, r_w[r_idx][j]};
        end
    end

`ifdef ARGMAX_EN
    logic [3:0]              w_best_idx;
    logic signed [ACC_W-1:0] w_best;
    logic [3:0]              r_class;

    // A strict greater-than keeps the lowest index when scores tie.
    always_comb begin
        w_best     = r_acc[0];
        w_best_idx = 4'd0;
        for (int j = 1; j < N_OUT; j++) begin
            if (r_acc[j] > w_best) begin
                w_best     = r_acc[j];
                w_best_idx = 4'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_class <= 4'd0;
        else if (r_state == ST_DONE) r_class <= w_best_idx;
    end

    assign class_out = r_class;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_end <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                r_act[k] <= '0;
                for (int j = 0; j < N_OUT; j++) r_w[k][j] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j]   <= '0;
                r_score[j] <= '0;
            end
        end else begin
            r_end <= 1'b0;
            if (w_we && !busy && (32'(w_addr) < N_IN)) begin
                for (int j = 0; j < N_OUT; j++)
                    r_w[w_addr][j] <= w_data[N_OUT*W_W-1-W_W*j -: W_W];
            end
            case (r_state)
                ST_ACC: begin
                    for (int j = 0; j < N_OUT; j++) r_acc[j] <= r_acc[j] + w_prod[j];
                    r_idx <= r_idx + 1'b1;
                end
                ST_DONE: begin
                    for (int j = 0; j < N_OUT; j++) r_score[j] <= r_acc[j];
                    r_end <= 1'b1;
                end
                default: ;
            endcase
            // A start in the DONE cycle clears acc only after it has been copied to the scores.
            if (w_accept) begin
                for (int k = 0; k < N_IN; k++)
                    r_act[k] <= in[N_IN*IN_W-1-IN_W*k -: IN_W];
                for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
                r_idx <= '0;
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out[N_OUT*ACC_W-1-ACC_W*j -: ACC_W] = r_score[j];
    end

endmodule

`default_nettype wire

// File: tb/tb_fully_connected_16_10.sv
// ============================================================================
// Module   : tb_fully_connected_16_10
// Brief    : Directed testbench for fully_connected_16_10 that checks its own
//            results against hand-computed scores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fully_connected_16_10;

    localparam int N_OUT = 10;
    localparam int ACC_W = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_flag;
    logic [63:0]   in;
    logic          w_we;
    logic [3:0]    w_addr;
    logic [79:0]   w_data;
    logic          busy;
    logic [169:0]  out;
    logic          end_flag;
`ifdef ARGMAX_EN
    logic [3:0]    class_out;
`endif

    int vectors = 0;
    int errors  = 0;

    fully_connected_16_10 dut (
        .clk        (clk),
        .reset      (reset),
        .start_flag (start_flag),
        .in         (in),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .busy       (busy),
        .out        (out),
`ifdef ARGMAX_EN
        .class_out  (class_out),
`endif
        .end_flag   (end_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [ACC_W-1:0] score(input int j);
        return out[N_OUT*ACC_W-1-ACC_W*j -: ACC_W];
    endfunction

    task automatic write_row(input logic [3:0] k, input logic [79:0] d);
        w_we = 1'b1; w_addr = k; w_data = d;
        tick();
        w_we = 1'b0;
    endtask

    task automatic write_all(input logic [7:0] v);
        for (int k = 0; k < 16; k++) write_row(4'(k), {N_OUT{v}});
    endtask

    // Pulses start, then counts cycles until end_flag shows up (bounded).
    task automatic run_frame(input logic [63:0] act, input string name);
        int n;
        in = act; start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
        n = 0;
        while (!end_flag && n < 40) begin tick(); n++; end
        vectors++;
        if (n !== 17) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected 17", name, n);
        end
    endtask

    task automatic check_all(input logic signed [ACC_W-1:0] exp, input string name);
        for (int j = 0; j < N_OUT; j++) begin
            vectors++;
            if (score(j) !== exp) begin
                errors++;
                $display("FAIL %s score[%0d]: got %0d, expected %0d", name, j, score(j), exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_flag = 1'b0; in = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({busy, end_flag, out} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b end=%b out=%h, expected all zero", busy, end_flag, out);
        end
    endtask

    task automatic test_zero_weights();
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, "zero_w");
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_w busy_at_end: got %b, expected 0", busy);
        end
        check_all(17'sd0, "zero_w");
        tick();
        vectors++;
        if (end_flag !== 1'b0) begin
            errors++;
            $display("FAIL zero_w end_pulse_width: got %b, expected 0", end_flag);
        end
    endtask

    task automatic test_identity();
        for (int k = 0; k < 16; k++) begin
            logic [79:0] d;
            d = '0;
            if (k < N_OUT) d[79-8*k -: 8] = 8'sd1;
            write_row(4'(k), d);
        end
        run_frame(64'h0123_4567_89AB_CDEF, "identity");
        for (int j = 0; j < N_OUT; j++) begin
            vectors++;
            if (score(j) !== 17'(j)) begin
                errors++;
                $display("FAIL identity score[%0d]: got %0d, expected %0d", j, score(j), j);
            end
        end
    endtask

    task automatic test_extremes();
        write_all(8'h80);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, "min_w");
        check_all(-17'sd30720, "min_w");
        write_all(8'h7F);
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, "max_w");
        check_all(17'sd30480, "max_w");
    endtask

    // Weights are 127 here. Frame 1 uses all-15 inputs and frame 2 uses all-1
    // inputs, which should score 127*16 = 2032.
    task automatic test_back_to_back();
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, "b2b_first");
        in = 64'h1111_1111_1111_1111; start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            if (n == 5) begin in = 64'hFFFF_FFFF_FFFF_FFFF; start_flag = 1'b1; end
            tick();
            start_flag = 1'b0;
            vectors++;
            if (end_flag !== (n == 17)) begin
                errors++;
                $display("FAIL b2b end_flag@%0d: got %b, expected %b", n, end_flag, (n == 17));
            end
        end
        check_all(17'sd2032, "b2b_second");
    endtask

    task automatic test_write_while_busy();
        int n;
        in = 64'h1111_1111_1111_1111; start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
        n = 0;
        w_we = 1'b1; w_data = {N_OUT{8'h80}};
        while (!end_flag && n < 40) begin
            w_addr = 4'(n);
            tick();
            n++;
            if (busy) w_we = 1'b1; else w_we = 1'b0;
        end
        w_we = 1'b0;
        check_all(17'sd2032, "wr_busy_frame");
        run_frame(64'h1111_1111_1111_1111, "wr_busy_after");
        check_all(17'sd2032, "wr_busy_after");
    endtask

    task automatic test_reset_mid_frame();
        int ends;
        in = 64'hFFFF_FFFF_FFFF_FFFF; start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, end_flag, out} !== '0) begin
            errors++;
            $display("FAIL mid_reset state: got busy=%b end=%b out=%h, expected zero", busy, end_flag, out);
        end
        tick();
        reset = 1'b0;
        ends = 0;
        for (int n = 0; n < 20; n++) begin tick(); if (end_flag) ends++; end
        vectors++;
        if (ends !== 0) begin
            errors++;
            $display("FAIL mid_reset end_flag_count: got %0d, expected 0", ends);
        end
        run_frame(64'hFFFF_FFFF_FFFF_FFFF, "mid_reset_wclr");
        check_all(17'sd0, "mid_reset_wclr");
    endtask

`ifdef ARGMAX_EN
    task automatic test_argmax();
        logic [79:0] d;
        d = {N_OUT{8'sd1}};
        d[79-8*3 -: 8] = 8'sd5;
        d[79-8*7 -: 8] = 8'sd5;
        write_row(4'd0, d);
        run_frame(64'h1000_0000_0000_0000, "argmax");
        vectors++;
        if (class_out !== 4'd3) begin
            errors++;
            $display("FAIL argmax class_out: got %0d, expected 3", class_out);
        end
        vectors++;
        if (score(7) !== 17'sd5) begin
            errors++;
            $display("FAIL argmax score[7]: got %0d, expected 5", score(7));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_weights();
        test_identity();
        test_extremes();
        test_back_to_back();
        test_write_while_busy();
        test_reset_mid_frame();
`ifdef ARGMAX_EN
        test_argmax();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
